// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks: receiver FSM state encoding, the
// default oversampling ratio and the clock-divider calculation used to derive
// the oversampling tick period from clock frequency and line rate.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } rx_state_e;

  // Clock cycles per oversampling tick, rounded down.
  function automatic int unsigned calc_tick_div(
    input int unsigned clk_freq,
    input int unsigned baud_rate,
    input int unsigned oversample
  );
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// The internal count runs 0..TICK_DIV-1 and the tick is high exactly in the
// cycle where the count equals TICK_DIV-1. The tick is registered: it is set
// one cycle ahead, when the count equals TICK_DIV-2.
// Ports:
//   i_clk  - system clock
//   i_rst  - asynchronous active-low reset (count and tick cleared)
//   o_tick - one-cycle tick pulse
// ---------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Divider count with wrap, and registered tick aligned to the last count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt  <= {CW{1'b0}};
      r_tick <= 1'b0;
    end else begin
      if (r_cnt == CW'(TICK_DIV - 1)) begin
        r_cnt <= {CW{1'b0}};
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_tick <= (r_cnt == CW'(TICK_DIV - 2));
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 16x-oversampled serial receiver for 8N1-style frames, LSB first.
// Ports:
//   i_clk       - system clock
//   i_rst       - asynchronous active-low reset
//   i_rx        - asynchronous serial line, idle high
//   i_rd        - one-cycle read strobe, consumes the current byte
//   o_data      - last received byte
//   o_valid     - sticky, unread byte present in o_data
//   o_overrun   - sticky, a byte was overwritten before being read
//   o_frame_err - one-cycle pulse when the stop bit is sampled low
//   o_busy      - receiver is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned NB_BITS    = 8,
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx,
  input  logic               i_rd,
  output logic [NB_BITS-1:0] o_data,
  output logic               o_valid,
  output logic               o_overrun,
  output logic               o_frame_err,
  output logic               o_busy
);

  localparam int unsigned TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned SCW      = $clog2(OVERSAMPLE);
  localparam int unsigned BCW      = $clog2(NB_BITS + 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("uart_rx: TICK_DIV must be >= 2");
  end
  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("uart_rx: OVERSAMPLE must be even and >= 4");
  end

  logic               w_tick;
  logic               r_sync1;
  logic               r_sync2;
  rx_state_e          r_state;
  rx_state_e          w_state_nxt;
  logic [SCW-1:0]     r_scnt;
  logic [SCW-1:0]     w_scnt_nxt;
  logic [BCW-1:0]     r_bcnt;
  logic [BCW-1:0]     w_bcnt_nxt;
  logic [NB_BITS-1:0] r_shift;
  logic [NB_BITS-1:0] w_shift_nxt;
  logic               w_done;
  logic               w_ferr;
  logic [NB_BITS-1:0] r_data;
  logic               r_valid;
  logic               r_overrun;
  logic               r_frame_err;

  uart_baud_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (w_tick)
  );

  // Two-flop synchroniser on the line; resets to the idle level.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // FSM, sample counter, bit counter and shift register state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_scnt  <= {SCW{1'b0}};
      r_bcnt  <= {BCW{1'b0}};
      r_shift <= {NB_BITS{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_scnt  <= w_scnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state logic; everything except IDLE/BRK moves only on ticks.
  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    w_bcnt_nxt  = r_bcnt;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_sync2) begin
          w_state_nxt = START;
          w_scnt_nxt  = {SCW{1'b0}};
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (!w_tick) begin
          w_state_nxt = START;
        end else if (r_scnt == SCW'(OVERSAMPLE / 2 - 1)) begin
          // Mid start bit: a high line here was only a glitch.
          if (!r_sync2) begin
            w_state_nxt = DATA;
            w_scnt_nxt  = {SCW{1'b0}};
            w_bcnt_nxt  = {BCW{1'b0}};
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_scnt_nxt = r_scnt + SCW'(1);
        end
      end
      DATA: begin
        if (!w_tick) begin
          w_state_nxt = DATA;
        end else if (r_scnt == SCW'(OVERSAMPLE - 1)) begin
          // LSB arrives first, so shift in at the top and move right.
          w_shift_nxt = {r_sync2, r_shift[NB_BITS-1:1]};
          w_bcnt_nxt  = r_bcnt + BCW'(1);
          w_scnt_nxt  = {SCW{1'b0}};
          if (r_bcnt == BCW'(NB_BITS - 1)) begin
            w_state_nxt = STOP;
          end else begin
            w_state_nxt = DATA;
          end
        end else begin
          w_scnt_nxt = r_scnt + SCW'(1);
        end
      end
      STOP: begin
        if (!w_tick) begin
          w_state_nxt = STOP;
        end else if (r_scnt == SCW'(OVERSAMPLE - 1)) begin
          w_scnt_nxt = {SCW{1'b0}};
          if (r_sync2) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            // Low stop bit: report once, then hold off until the line idles
            // so a break is not decoded as a stream of zero bytes.
            w_ferr      = 1'b1;
            w_state_nxt = BRK;
          end
        end else begin
          w_scnt_nxt = r_scnt + SCW'(1);
        end
      end
      BRK: begin
        if (r_sync2) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BRK;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Bus-facing byte, sticky status flags and frame-error pulse.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_data      <= {NB_BITS{1'b0}};
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      if (w_done) begin
        // A read landing on the completion cycle consumed the old byte,
        // so only an unread old byte counts as an overrun.
        r_data  <= r_shift;
        r_valid <= 1'b1;
        if (r_valid && !i_rd) begin
          r_overrun <= 1'b1;
        end
      end else if (i_rd && r_valid) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_overrun   = r_overrun;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx at TICK_DIV=10 (bit time = 160 clocks).
// Frames are launched aligned to the reference tick phase so the exact
// completion cycle (1520 clocks after the start edge) is known in advance.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BIT_CLKS = 160;
  localparam int DONE_CYC = 1519;   // cycle during which the stop bit is taken
  localparam int NV       = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rd;
  logic [7:0] data;
  logic       valid;
  logic       ovr;
  logic       ferr;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int m_tcnt;
  int valid_rise_cyc = -1;
  int busy_fall_cyc  = -1;
  int ferr_edges     = 0;
  int ferr_cycles    = 0;
  logic prev_valid   = 1'b0;
  logic prev_busy    = 1'b0;
  logic prev_ferr    = 1'b0;
  logic busy_snap;

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    bit         rd_before;
    int         rd_cyc;
    bit         rd_after;
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_ovr;
    int         exp_ferr;
  } vec_t;

  vec_t tv [NV];

  uart_rx #(
    .NB_BITS    (8),
    .CLK_FREQ   (1600000),
    .BAUD_RATE  (10000),
    .OVERSAMPLE (16)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_rx        (rx),
    .i_rd        (rd),
    .o_data      (data),
    .o_valid     (valid),
    .o_overrun   (ovr),
    .o_frame_err (ferr),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference phase of the free-running tick divider (0..9).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_tcnt <= 0;
    else        m_tcnt <= (m_tcnt == 9) ? 0 : m_tcnt + 1;
  end

  // Edge/pulse monitor sampled mid-cycle.
  always @(negedge clk) begin
    prev_valid <= valid;
    prev_busy  <= busy;
    prev_ferr  <= ferr;
    if (valid && !prev_valid) valid_rise_cyc <= cyc;
    if (!busy && prev_busy)   busy_fall_cyc  <= cyc;
    if (ferr)                 ferr_cycles    <= ferr_cycles + 1;
    if (ferr && !prev_ferr)   ferr_edges     <= ferr_edges + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  // Drive one frame; stop bit held low for stop_low bit times before the
  // final high stop bit. rd is raised during cycle rd_cyc of the frame.
  task automatic send_frame(input logic [7:0] b, input int stop_low, input int rd_cyc,
                            output int start_cyc);
    int n;
    int bi;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (m_tcnt != 0 && n < 20);
    if (m_tcnt != 0) chk("tick_align", m_tcnt, 0);
    start_cyc = cyc;
    for (int c = 0; c < BIT_CLKS * (10 + stop_low); c++) begin
      bi = c / BIT_CLKS;
      if (bi == 0)                 rx = 1'b0;
      else if (bi <= 8)            rx = b[bi-1];
      else if (bi < 9 + stop_low)  rx = 1'b0;
      else                         rx = 1'b1;
      rd = (c == rd_cyc);
      if (c == BIT_CLKS * (9 + stop_low) - 1) busy_snap = busy;
      @(posedge clk); #1;
    end
    rd = 1'b0;
    rx = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int e0;
    int f0;

    tv[0] = '{8'hA5, 0, 1'b0, -1,       1'b0, 8'hA5, 1'b1, 1'b0, 0};
    tv[1] = '{8'h3C, 0, 1'b1, -1,       1'b0, 8'h3C, 1'b1, 1'b0, 0};
    tv[2] = '{8'h81, 0, 1'b0, -1,       1'b1, 8'h81, 1'b1, 1'b1, 0};
    tv[3] = '{8'h55, 2, 1'b0, -1,       1'b0, 8'h81, 1'b0, 1'b0, 1};
    tv[4] = '{8'h0F, 0, 1'b0, -1,       1'b1, 8'h0F, 1'b1, 1'b0, 0};
    tv[5] = '{8'h12, 0, 1'b0, -1,       1'b0, 8'h12, 1'b1, 1'b0, 0};
    tv[6] = '{8'h34, 0, 1'b0, DONE_CYC, 1'b1, 8'h34, 1'b1, 1'b0, 0};

    // Reset with idle line.
    rst_n = 1'b0; rx = 1'b1; rd = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_data",  data,  8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ovr",   ovr,   1'b0);
    chk("rst_ferr",  ferr,  1'b0);
    chk("rst_busy",  busy,  1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;

    // Short low glitch: START entered, rejected at mid-bit check.
    rx = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("glitch_busy_hi", busy, 1'b1);
    repeat (20) @(posedge clk); #1;
    rx = 1'b1;
    repeat (200) @(posedge clk); #1;
    chk("glitch_busy_lo", busy,       1'b0);
    chk("glitch_valid",   valid,      1'b0);
    chk("glitch_data",    data,       8'h00);
    chk("glitch_ferr",    ferr_edges, 0);

    // Table of frames.
    for (int i = 0; i < NV; i++) begin
      if (tv[i].rd_before) pulse_rd();
      e0 = ferr_edges;
      f0 = ferr_cycles;
      send_frame(tv[i].data, tv[i].stop_low, tv[i].rd_cyc, sc);
      repeat (4) @(posedge clk); #1;
      chk($sformatf("v%0d_data", i),  data,  tv[i].exp_data);
      chk($sformatf("v%0d_valid", i), valid, tv[i].exp_valid);
      chk($sformatf("v%0d_ovr", i),   ovr,   tv[i].exp_ovr);
      chk($sformatf("v%0d_busy", i),  busy,  1'b0);
      chk($sformatf("v%0d_ferr_pulses", i), ferr_edges - e0,  tv[i].exp_ferr);
      chk($sformatf("v%0d_ferr_cycles", i), ferr_cycles - f0, tv[i].exp_ferr);
      if (i == 0) begin
        chk("v0_valid_latency", valid_rise_cyc - sc, DONE_CYC + 1);
        chk("v0_busy_latency",  busy_fall_cyc - sc,  DONE_CYC + 1);
      end
      if (tv[i].stop_low > 0) chk($sformatf("v%0d_brk_busy", i), busy_snap, 1'b1);
      if (tv[i].rd_after) begin
        pulse_rd();
        chk($sformatf("v%0d_rd_valid", i), valid, 1'b0);
        chk($sformatf("v%0d_rd_ovr", i),   ovr,   1'b0);
      end
    end

    // Reset in the middle of the data bits of 0xFF.
    e0 = ferr_edges;
    rx = 1'b0;
    repeat (BIT_CLKS) @(posedge clk); #1;
    rx = 1'b1;
    repeat (440) @(posedge clk); #1;
    chk("midrst_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_data",  data,  8'h00);
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_busy",  busy,  1'b0);
    chk("midrst_ferr",  ferr,  1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (1200) @(posedge clk); #1;
    chk("postrst_valid", valid, 1'b0);
    chk("postrst_busy",  busy,  1'b0);
    send_frame(8'h7E, 0, -1, sc);
    repeat (4) @(posedge clk); #1;
    chk("postrst_data",   data,  8'h7E);
    chk("postrst_valid2", valid, 1'b1);
    chk("postrst_ovr",    ovr,   1'b0);
    chk("postrst_noferr", ferr_edges - e0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
